// File: rtl/mem_access_pkg.sv
// Shared types and constants for the MEM-stage data access unit and its
// tag/data storage.
package mem_access_pkg;

  localparam int OFFSET_W       = 5;
  localparam int WORD_W         = 32;
  localparam int WORDS_PER_LINE = 8;
  localparam int WORD_SEL_W     = $clog2(WORDS_PER_LINE);
  localparam int LINE_W         = WORD_W * WORDS_PER_LINE;

  localparam int NUM_LINES_DEF  = 16;
  localparam int ADDR_W_DEF     = 32;
  localparam int INDEX_W        = $clog2(NUM_LINES_DEF);
  localparam int TAG_W          = ADDR_W_DEF - INDEX_W - OFFSET_W;

  // Controller states, kept as plain constants for compatibility with older tools.
  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_MISS      = 3'd1;
  localparam logic [2:0] ST_WRITEBACK = 3'd2;
  localparam logic [2:0] ST_ALLOCATE  = 3'd3;
  localparam logic [2:0] ST_REFILL    = 3'd4;

  // Pick one 32-bit word out of a cache line.
  function automatic logic [WORD_W-1:0] line_word(input logic [LINE_W-1:0]     line,
                                                   input logic [WORD_SEL_W-1:0] sel);
    return line[sel*WORD_W +: WORD_W];
  endfunction

endpackage

// File: rtl/dcache_tag_data_array.sv
// Tag, valid, dirty and data storage for the direct-mapped data cache.
// Reads are asynchronous; writes are either a full line refill or a single
// store word.
module dcache_tag_data_array
  import mem_access_pkg::*;
#(
  parameter int NUM_LINES = NUM_LINES_DEF,
  parameter int LINE_BITS = LINE_W,
  parameter int INDEX_W   = mem_access_pkg::INDEX_W,
  parameter int TAG_W     = mem_access_pkg::TAG_W
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [INDEX_W-1:0]    index,
  output logic [TAG_W-1:0]      rd_tag,
  output logic                  rd_valid,
  output logic                  rd_dirty,
  output logic [LINE_BITS-1:0]  rd_line,
  input  logic                  line_we,
  input  logic [TAG_W-1:0]      line_tag,
  input  logic [LINE_BITS-1:0]  line_data,
  input  logic                  word_we,
  input  logic [WORD_SEL_W-1:0] word_sel,
  input  logic [WORD_W-1:0]     word_data
);

  logic [TAG_W-1:0]     tag_q  [NUM_LINES];
  logic [LINE_BITS-1:0] data_q [NUM_LINES];
  logic [NUM_LINES-1:0] valid_q;
  logic [NUM_LINES-1:0] dirty_q;

  assign rd_tag   = tag_q[index];
  assign rd_valid = valid_q[index];
  assign rd_dirty = dirty_q[index];
  assign rd_line  = data_q[index];

  // Storage update: a refill installs a clean line, a store marks it dirty.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      valid_q <= '0;
      dirty_q <= '0;
      // NOTE: tag and data words are cleared too, so this storage has to stay
      // in flops; a RAM macro cannot be reset like this.
      for (int i = 0; i < NUM_LINES; i++) begin
        tag_q[i]  <= '0;
        data_q[i] <= '0;
      end
    end else if (line_we) begin
      // NOTE: non-blocking assignments everywhere here, so reads in the same
      // cycle see the old contents regardless of block ordering.
      tag_q[index]   <= line_tag;
      data_q[index]  <= line_data;
      valid_q[index] <= 1'b1;
      dirty_q[index] <= 1'b0;
    end else if (word_we) begin
      data_q[index][word_sel*WORD_W +: WORD_W] <= word_data;
      dirty_q[index] <= 1'b1;
    end
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage data access unit: direct-mapped, write-back, write-allocate
// cache in front of a slow line-wide memory. Hits complete in zero cycles;
// misses stall the pipeline until the line has been refilled and the access
// is retried as a hit.
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int NUM_LINES = NUM_LINES_DEF,
  parameter int LINE_BITS = LINE_W,
  parameter int ADDR_W    = ADDR_W_DEF
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [ADDR_W-1:0]    addr_i,
  input  logic [WORD_W-1:0]    wdata_i,
  input  logic                 mem_read_i,
  input  logic                 mem_write_i,
  output logic [WORD_W-1:0]    rdata_o,
  output logic                 stall_o,
  output logic                 mem_enable_o,
  output logic                 mem_write_o,
  output logic [ADDR_W-1:0]    mem_addr_o,
  output logic [LINE_BITS-1:0] mem_data_o,
  input  logic [LINE_BITS-1:0] mem_data_i,
  input  logic                 mem_ack_i
);

  localparam int IDX_W    = $clog2(NUM_LINES);
  localparam int TAG_BITS = ADDR_W - IDX_W - OFFSET_W;

  logic [2:0]            state_q;
  logic [2:0]            state_d;
  logic [IDX_W-1:0]      index;
  logic [TAG_BITS-1:0]   tag;
  logic [WORD_SEL_W-1:0] word_sel;
  logic [TAG_BITS-1:0]   rd_tag;
  logic                  rd_valid;
  logic                  rd_dirty;
  logic [LINE_BITS-1:0]  rd_line;
  logic                  req;
  logic                  hit;
  logic                  line_we;
  logic                  word_we;
  logic                  unused_byte_bits;

  // Address split; the byte offset within a word is ignored (word accesses only).
  assign index            = addr_i[OFFSET_W +: IDX_W];
  assign tag              = addr_i[ADDR_W-1 -: TAG_BITS];
  assign word_sel         = addr_i[OFFSET_W-1 -: WORD_SEL_W];
  assign unused_byte_bits = ^addr_i[1:0];

  // A simultaneous read and write is treated as a store.
  assign req = mem_read_i | mem_write_i;
  assign hit = rd_valid && (rd_tag == tag);

  // Refill on the ALLOCATE acknowledge; store on a hit seen in IDLE.
  assign line_we = (state_q == ST_ALLOCATE) && mem_ack_i;
  assign word_we = (state_q == ST_IDLE) && hit && mem_write_i;

  dcache_tag_data_array #(
    .NUM_LINES (NUM_LINES),
    .LINE_BITS (LINE_BITS),
    .INDEX_W   (IDX_W),
    .TAG_W     (TAG_BITS)
  ) u_array (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .index     (index),
    .rd_tag    (rd_tag),
    .rd_valid  (rd_valid),
    .rd_dirty  (rd_dirty),
    .rd_line   (rd_line),
    .line_we   (line_we),
    .line_tag  (tag),
    .line_data (mem_data_i),
    .word_we   (word_we),
    .word_sel  (word_sel),
    .word_data (wdata_i)
  );

  // Controller state register.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic: miss -> (writeback) -> allocate -> refill -> retry.
  always_comb begin
    // NOTE: default first, so no branch of the case can infer a latch.
    state_d = state_q;
    case (state_q)
      ST_IDLE:      if (req && !hit) state_d = ST_MISS;
      ST_MISS:      state_d = (rd_valid && rd_dirty) ? ST_WRITEBACK : ST_ALLOCATE;
      ST_WRITEBACK: if (mem_ack_i) state_d = ST_ALLOCATE;
      ST_ALLOCATE:  if (mem_ack_i) state_d = ST_REFILL;
      ST_REFILL:    state_d = ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase
  end

  // Memory request fields; the victim tag is read from the array, which is
  // not modified until the refill, so nothing needs latching.
  always_comb begin
    mem_enable_o = 1'b0;
    mem_write_o  = 1'b0;
    mem_addr_o   = '0;
    mem_data_o   = '0;
    case (state_q)
      ST_WRITEBACK: begin
        mem_enable_o = 1'b1;
        mem_write_o  = 1'b1;
        mem_addr_o   = {rd_tag, index, {OFFSET_W{1'b0}}};
        mem_data_o   = rd_line;
      end
      ST_ALLOCATE: begin
        mem_enable_o = 1'b1;
        mem_addr_o   = {tag, index, {OFFSET_W{1'b0}}};
      end
      default: ;
    endcase
  end

  // Pipeline-facing outputs; stall drops with reset even if a request is held.
  always_comb begin
    stall_o = rst_i && ((state_q != ST_IDLE) || (req && !hit));
    rdata_o = ((state_q == ST_IDLE) && hit) ? line_word(rd_line, word_sel) : '0;
  end

endmodule

// File: tb/tb_mem_access_unit.sv
`timescale 1ns/1ps
module tb_mem_access_unit;

  logic         clk_i = 1'b0;
  logic         rst_i = 1'b1;
  logic [31:0]  addr_i = '0;
  logic [31:0]  wdata_i = '0;
  logic         mem_read_i = 1'b0;
  logic         mem_write_i = 1'b0;
  logic [31:0]  rdata_o;
  logic         stall_o;
  logic         mem_enable_o;
  logic         mem_write_o;
  logic [31:0]  mem_addr_o;
  logic [255:0] mem_data_o;
  logic [255:0] mem_data_i = '0;
  logic         mem_ack_i = 1'b0;

  always #5 clk_i = ~clk_i;

  mem_access_unit dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .addr_i       (addr_i),
    .wdata_i      (wdata_i),
    .mem_read_i   (mem_read_i),
    .mem_write_i  (mem_write_i),
    .rdata_o      (rdata_o),
    .stall_o      (stall_o),
    .mem_enable_o (mem_enable_o),
    .mem_write_o  (mem_write_o),
    .mem_addr_o   (mem_addr_o),
    .mem_data_o   (mem_data_o),
    .mem_data_i   (mem_data_i),
    .mem_ack_i    (mem_ack_i)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // ---------------- memory model and transaction log ----------------
  typedef struct {
    logic         we;
    logic [31:0]  addr;
    logic [255:0] data;
  } txn_t;

  txn_t         txn_log[$];
  logic [255:0] mem_model [int unsigned];
  int           mem_lat  = 4;
  int           wait_cnt = 0;
  logic [31:0]  hold_addr;
  logic         hold_we;

  task automatic ensure_line(input logic [31:0] addr);
    int unsigned  k = addr >> 5;
    logic [255:0] l;
    if (!mem_model.exists(k)) begin
      for (int w = 0; w < 8; w++) l[w*32 +: 32] = $urandom;
      mem_model[k] = l;
    end
  endtask

  // Slow memory: acknowledges the mem_lat-th cycle of each request and
  // checks that the request fields stay put while it waits.
  always @(negedge clk_i) begin
    if (mem_enable_o) begin
      wait_cnt++;
      if (wait_cnt == 1) begin
        hold_addr = mem_addr_o;
        hold_we   = mem_write_o;
      end else begin
        check("req_addr_stable", mem_addr_o, hold_addr);
        check("req_we_stable", mem_write_o, hold_we);
      end
      if (wait_cnt >= mem_lat) begin
        txn_log.push_back(txn_t'{mem_write_o, mem_addr_o, mem_data_o});
        if (mem_write_o) begin
          mem_model[mem_addr_o >> 5] = mem_data_o;
        end else begin
          ensure_line(mem_addr_o);
          mem_data_i = mem_model[mem_addr_o >> 5];
        end
        mem_ack_i = 1'b1;
        wait_cnt  = 0;
      end else begin
        mem_ack_i = 1'b0;
      end
    end else begin
      mem_ack_i = 1'b0;
      wait_cnt  = 0;
    end
  end

  // ---------------- cache reference model ----------------
  bit           m_valid [16];
  bit           m_dirty [16];
  logic [22:0]  m_tag   [16];
  logic [255:0] m_line  [16];
  int           last_stall;
  logic [31:0]  last_rdata;

  task automatic do_access(input logic [31:0] addr, input logic rd, input logic wr,
                           input logic [31:0] wd, input int lat, input string name);
    int          idx = int'(addr[8:5]);
    logic [22:0] tg  = addr[31:9];
    int          w   = int'(addr[4:2]);
    bit          hit = m_valid[idx] && (m_tag[idx] == tg);
    int          exp_stall = 0;
    int          cyc = 0;
    logic [31:0] exp_rd;
    txn_t        exp_q[$];

    if (!hit) begin
      exp_stall = 3 + lat;
      if (m_valid[idx] && m_dirty[idx]) begin
        exp_stall += lat;
        exp_q.push_back(txn_t'{1'b1, {m_tag[idx], addr[8:5], 5'b0}, m_line[idx]});
      end
      ensure_line(addr);
      exp_q.push_back(txn_t'{1'b0, {tg, addr[8:5], 5'b0}, 256'b0});
      m_line[idx]  = mem_model[addr >> 5];
      m_tag[idx]   = tg;
      m_valid[idx] = 1'b1;
      m_dirty[idx] = 1'b0;
    end
    exp_rd = m_line[idx][w*32 +: 32];
    if (wr) begin
      m_line[idx][w*32 +: 32] = wd;
      m_dirty[idx] = 1'b1;
    end

    mem_lat = lat;
    txn_log.delete();
    @(negedge clk_i);
    addr_i      = addr;
    wdata_i     = wd;
    mem_read_i  = rd;
    mem_write_i = wr;
    #1;
    while (stall_o && cyc < 500) begin
      cyc++;
      @(negedge clk_i);
      #1;
    end
    last_stall = cyc;
    last_rdata = rdata_o;
    check({name, "_stall_cycles"}, cyc, exp_stall);
    if (rd && !wr) check({name, "_rdata"}, rdata_o, exp_rd);
    @(posedge clk_i);
    #1;
    mem_read_i  = 1'b0;
    mem_write_i = 1'b0;
    check({name, "_num_mem_txn"}, txn_log.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < txn_log.size(); i++) begin
      check({name, "_txn_we"}, txn_log[i].we, exp_q[i].we);
      check({name, "_txn_addr"}, txn_log[i].addr, exp_q[i].addr);
      if (exp_q[i].we) check({name, "_txn_data"}, txn_log[i].data, exp_q[i].data);
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < 16; i++) begin
      m_valid[i] = 1'b0;
      m_dirty[i] = 1'b0;
    end
  endtask

  // ---------------- stimulus ----------------
  logic [255:0] seed_line;
  logic [31:0]  ra;
  int           op;
  int           cyc;

  initial begin
    clear_model();
    #1 rst_i = 1'b0;
    repeat (2) @(negedge clk_i);
    #1;
    check("rst_stall", stall_o, 1'b0);
    check("rst_mem_enable", mem_enable_o, 1'b0);
    check("rst_mem_write", mem_write_o, 1'b0);
    check("rst_rdata", rdata_o, 32'h0);
    check("rst_mem_addr", mem_addr_o, 32'h0);
    check("rst_mem_data", mem_data_o, 256'h0);
    @(negedge clk_i);
    rst_i = 1'b1;

    // Cold load: 4-cycle memory, word1 of line 0x100 preset.
    for (int w = 0; w < 8; w++) seed_line[w*32 +: 32] = $urandom;
    seed_line[63:32] = 32'hDEAD_BEEF;
    mem_model[32'h100 >> 5] = seed_line;
    do_access(32'h0000_0104, 1'b1, 1'b0, 32'h0, 4, "cold");
    check("cold_rdata_value", last_rdata, 32'hDEAD_BEEF);
    check("cold_stall_is_7", last_stall, 7);
    if (txn_log.size() > 0) check("cold_alloc_addr", txn_log[0].addr, 32'h0000_0100);

    // Store hit, then load it back with no stall and no memory traffic.
    do_access(32'h0000_0104, 1'b0, 1'b1, 32'h1234_5678, 4, "store_hit");
    check("store_hit_no_stall", last_stall, 0);
    do_access(32'h0000_0104, 1'b1, 1'b0, 32'h0, 4, "load_after_store");
    check("load_after_store_value", last_rdata, 32'h1234_5678);

    // Dirty eviction: same index 8, new tag.
    do_access(32'h0000_0304, 1'b1, 1'b0, 32'h0, 3, "evict");
    check("evict_txn_count", txn_log.size(), 2);
    if (txn_log.size() >= 2) begin
      check("evict_wb_we", txn_log[0].we, 1'b1);
      check("evict_wb_addr", txn_log[0].addr, 32'h0000_0100);
      check("evict_wb_word1", txn_log[0].data[63:32], 32'h1234_5678);
      check("evict_alloc_we", txn_log[1].we, 1'b0);
      check("evict_alloc_addr", txn_log[1].addr, 32'h0000_0300);
    end

    // Simultaneous read+write on a hit line acts as a store and dirties it.
    do_access(32'h0000_0308, 1'b1, 1'b1, 32'hCAFE_F00D, 3, "rd_wr");
    check("rd_wr_no_stall", last_stall, 0);
    do_access(32'h0000_0108, 1'b1, 1'b0, 32'h0, 2, "rd_wr_evict");
    if (txn_log.size() >= 1) check("rd_wr_wb_word2", txn_log[0].data[95:64], 32'hCAFE_F00D);

    // Long latency: 20-cycle memory, request fields checked every cycle.
    do_access(32'h0000_1010, 1'b1, 1'b0, 32'h0, 20, "long_lat");
    check("long_lat_stall_23", last_stall, 23);

    // Reset while a write-back is outstanding.
    do_access(32'h0000_02A0, 1'b0, 1'b1, 32'h5555_AAAA, 2, "pre_rst_store");
    mem_lat = 50;
    txn_log.delete();
    @(negedge clk_i);
    addr_i     = 32'h0000_04A0;
    mem_read_i = 1'b1;
    #1;
    cyc = 0;
    while (!(mem_enable_o && mem_write_o) && cyc < 20) begin
      cyc++;
      @(negedge clk_i);
      #1;
    end
    check("rst_mid_wb_reached", mem_enable_o && mem_write_o, 1'b1);
    repeat (3) @(negedge clk_i);
    #2 rst_i = 1'b0;
    #1;
    check("rst_mid_enable_drop", mem_enable_o, 1'b0);
    check("rst_mid_stall_drop", stall_o, 1'b0);
    check("rst_mid_addr_zero", mem_addr_o, 32'h0);
    mem_read_i = 1'b0;
    @(negedge clk_i);
    rst_i = 1'b1;
    clear_model();
    check("rst_mid_no_txn", txn_log.size(), 0);
    do_access(32'h0000_02A0, 1'b1, 1'b0, 32'h0, 3, "post_rst_miss");
    check("post_rst_clean_miss", last_stall, 6);

    // Randomised mix over 4 tags x 16 indices.
    for (int n = 0; n < 200; n++) begin
      op = $urandom_range(0, 5);
      ra = ($urandom_range(0, 3) << 9) | ($urandom_range(0, 15) << 5) |
           ($urandom_range(0, 7) << 2) | $urandom_range(0, 3);
      case (op)
        0: begin
          @(negedge clk_i);
          #1;
          check("idle_stall", stall_o, 1'b0);
          check("idle_mem_enable", mem_enable_o, 1'b0);
        end
        1, 2:    do_access(ra, 1'b1, 1'b0, 32'h0, $urandom_range(1, 6), "rnd_load");
        3, 4:    do_access(ra, 1'b0, 1'b1, $urandom, $urandom_range(1, 6), "rnd_store");
        default: do_access(ra, 1'b1, 1'b1, $urandom, $urandom_range(1, 6), "rnd_rdwr");
      endcase
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
